// File: rtl/iiitb_sd_seq_gen.sv
// -----------------------------------------------------------------------------
// iiitb_sd_seq_gen
//
// Serial sequence transmitter. A parallel pattern, its length and a repeat
// count are captured on a start request while idle. The pattern is then
// shifted out MSB first (bit [L-1] down to bit 0), one bit per clock. The
// pattern is sent repeat_count+1 times, with GAP idle cycles between copies.
// A one-cycle done pulse follows the final bit. This block feeds the stream
// consumed by the Moore sequence detector (iiitb_sd_fsm).
//
// Parameters
//   WIDTH  maximum pattern length in bits
//   LEN_W  width of the length input (must be able to hold WIDTH)
//   REP_W  width of the repeat input
//   GAP    idle cycles inserted between repetitions (0 = back-to-back)
//
// Ports
//   clock         in   rising-edge system clock
//   reset         in   synchronous, active-high reset
//   start         in   send request, only honoured while idle
//   pattern       in   [WIDTH-1:0] bits to send, bit [L-1] first
//   length        in   [LEN_W-1:0] bits per copy; 0 or >WIDTH means WIDTH
//   repeat_count  in   [REP_W-1:0] extra copies (total = repeat_count+1).
//                      Named repeat_count because "repeat" is a reserved word.
//   sequence_out  out  registered serial data bit
//   seq_valid     out  high while sequence_out carries a pattern bit
//   busy          out  high from the first bit through the last bit
//   done          out  one-cycle pulse in the cycle after the final bit
// -----------------------------------------------------------------------------
module iiitb_sd_seq_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    input  logic [REP_W-1:0] repeat_count,
    output logic             sequence_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    // Gap counter holds "gap cycles still to come after this one" (0..GAP-1).
    localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [WIDTH-1:0] BIT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // State and captured transfer parameters
    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_pattern;
    logic [WIDTH-1:0]   w_pattern_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len_next;
    logic [LEN_W-1:0]   r_bit_idx;      // index of the bit currently on the output
    logic [LEN_W-1:0]   w_bit_idx_next;
    logic [REP_W-1:0]   r_rep_left;     // copies still to send after the current one
    logic [REP_W-1:0]   w_rep_left_next;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_cnt_next;

    // Registered outputs
    logic               r_seq_out;
    logic               w_seq_out_next;
    logic               r_valid;
    logic               w_valid_next;
    logic               r_busy;
    logic               w_busy_next;
    logic               r_done;
    logic               w_done_next;

    // Effective length: 0 or anything above WIDTH selects the full width.
    logic [LEN_W-1:0]   w_len_eff;
    // Candidate bits for the three places a new bit can be launched from.
    logic               w_first_bit;    // pattern[L-1] of the incoming request
    logic               w_step_bit;     // r_pattern[idx-1], next bit in this copy
    logic               w_restart_bit;  // r_pattern[L-1], first bit of next copy

    assign w_len_eff = ((length == '0) || (length > LEN_MAX)) ? LEN_MAX : length;

    // Bit selects done as masks so the select index may be wider than needed.
    assign w_first_bit   = |(pattern   & (BIT_ONE << (w_len_eff - LEN_ONE)));
    assign w_step_bit    = |(r_pattern & (BIT_ONE << (r_bit_idx - LEN_ONE)));
    assign w_restart_bit = |(r_pattern & (BIT_ONE << (r_len     - LEN_ONE)));

    // -------------------------------------------------------------------------
    // State / output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pattern  <= '0;
            r_len      <= '0;
            r_bit_idx  <= '0;
            r_rep_left <= '0;
            r_gap_cnt  <= '0;
            r_seq_out  <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pattern  <= w_pattern_next;
            r_len      <= w_len_next;
            r_bit_idx  <= w_bit_idx_next;
            r_rep_left <= w_rep_left_next;
            r_gap_cnt  <= w_gap_cnt_next;
            r_seq_out  <= w_seq_out_next;
            r_valid    <= w_valid_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic. The output registers are loaded with
    // what the block shows in the following cycle, so every output is a flop.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_pattern_next  = r_pattern;
        w_len_next      = r_len;
        w_bit_idx_next  = r_bit_idx;
        w_rep_left_next = r_rep_left;
        w_gap_cnt_next  = r_gap_cnt;
        w_seq_out_next  = 1'b0;
        w_valid_next    = 1'b0;
        w_busy_next     = 1'b0;
        w_done_next     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The first bit is launched on the accepting edge itself.
                if (start) begin
                    w_pattern_next  = pattern;
                    w_len_next      = w_len_eff;
                    w_rep_left_next = repeat_count;
                    w_bit_idx_next  = w_len_eff - LEN_ONE;
                    w_seq_out_next  = w_first_bit;
                    w_valid_next    = 1'b1;
                    w_busy_next     = 1'b1;
                    w_state_next    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (r_bit_idx != '0) begin
                    w_bit_idx_next = r_bit_idx - LEN_ONE;
                    w_seq_out_next = w_step_bit;
                    w_valid_next   = 1'b1;
                    w_busy_next    = 1'b1;
                end else if (r_rep_left != '0) begin
                    w_rep_left_next = r_rep_left - 1'b1;
                    w_busy_next     = 1'b1;
                    if (GAP > 0) begin
                        w_gap_cnt_next = GAP_W'(GAP - 1);
                        w_state_next   = ST_GAP;
                    end else begin
                        // Back-to-back copies: no bubble between bit 0 and bit L-1.
                        w_bit_idx_next = r_len - LEN_ONE;
                        w_seq_out_next = w_restart_bit;
                        w_valid_next   = 1'b1;
                    end
                end else begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end

            ST_GAP: begin
                w_busy_next = 1'b1;
                if (r_gap_cnt == '0) begin
                    w_bit_idx_next = r_len - LEN_ONE;
                    w_seq_out_next = w_restart_bit;
                    w_valid_next   = 1'b1;
                    w_state_next   = ST_SHIFT;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign sequence_out = r_seq_out;
    assign seq_valid    = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
